// File: rtl/multi_tone_generator_if.sv
// -----------------------------------------------------------------------------
// multi_tone_generator_if
// Channel-load write bus for multi_tone_generator.
//   wr_en     : one-cycle channel-load strobe
//   wr_ch     : target channel (values >= NUM_CH are ignored by the generator)
//   wr_period : half-period in clk cycles, 0 stops the channel
//   wr_dur    : duration in ticks, 0 means continuous
//   wr_fuzz   : jitter mask (only used when TONE_FUZZ_EN is defined)
// Modports: master drives the bus, slave (the generator) receives it.
// -----------------------------------------------------------------------------
interface multi_tone_generator_if #(
    parameter int NUM_CH = 4,
    parameter int PER_W  = 20,
    parameter int DUR_W  = 16
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic             wr_en;
    logic [CH_W-1:0]  wr_ch;
    logic [PER_W-1:0] wr_period;
    logic [DUR_W-1:0] wr_dur;
    logic [7:0]       wr_fuzz;

    modport master (
        output wr_en, wr_ch, wr_period, wr_dur, wr_fuzz
    );

    modport slave (
        input  wr_en, wr_ch, wr_period, wr_dur, wr_fuzz
    );
endinterface

// File: rtl/multi_tone_generator.sv
// -----------------------------------------------------------------------------
// multi_tone_generator
// NUM_CH independent square-wave tone channels with optional duration and
// jitter, mixed into a 1-bit first-order sigma-delta audio stream.
//
// Ports:
//   clk       : system clock, all logic on rising edge
//   resetn    : asynchronous active-low reset
//   wr        : channel-load bus (multi_tone_generator_if.slave)
//   active    : per-channel sounding flags
//   tone      : per-channel square waves
//   done      : per-channel one-cycle duration-expiry pulses
//   audio_out : mixed 1-bit audio
//
// Optional feature macro: TONE_FUZZ_EN
//   defined   -> 8-bit LFSR (x^8+x^6+x^5+x^4+1) jitters each half-period by
//                lfsr & fuzz mask
//   undefined -> no LFSR, half-periods are exact, wr_fuzz is ignored
// -----------------------------------------------------------------------------
module multi_tone_generator #(
    parameter int CLK_HZ  = 27000000,
    parameter int NUM_CH  = 4,
    parameter int PER_W   = 20,
    parameter int DUR_W   = 16,
    parameter int TICK_HZ = 1000
) (
    input  logic                    clk,
    input  logic                    resetn,
    multi_tone_generator_if.slave   wr,
    output logic [NUM_CH-1:0]       active,
    output logic [NUM_CH-1:0]       tone,
    output logic [NUM_CH-1:0]       done,
    output logic                    audio_out
);

    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W    = PER_W + 1;
    localparam int TICK_DIV = (CLK_HZ / TICK_HZ > 0) ? (CLK_HZ / TICK_HZ) : 1;
    localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SUM_W    = $clog2(2 * NUM_CH) + 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic              tick;

    logic [NUM_CH-1:0] active_q, active_d;
    logic [NUM_CH-1:0] tone_q,   tone_d;
    logic [NUM_CH-1:0] done_q,   done_d;
    logic [PER_W-1:0]  period_q [NUM_CH];
    logic [PER_W-1:0]  period_d [NUM_CH];
    logic [CNT_W-1:0]  count_q  [NUM_CH];
    logic [CNT_W-1:0]  count_d  [NUM_CH];
    logic [DUR_W-1:0]  rem_q    [NUM_CH];
    logic [DUR_W-1:0]  rem_d    [NUM_CH];

    logic [CH_W-1:0]   acc_q, acc_d;
    logic              audio_q, audio_d;
    logic [SUM_W-1:0]  ones;
    logic [SUM_W-1:0]  sum;

    logic [CNT_W-1:0]  lim;
    logic [7:0]        fz;

`ifdef TONE_FUZZ_EN
    logic [7:0]        lfsr_q, lfsr_d;
    logic [7:0]        fuzz_q     [NUM_CH];
    logic [7:0]        fuzz_d     [NUM_CH];
    logic [7:0]        fuzz_cur_q [NUM_CH];
    logic [7:0]        fuzz_cur_d [NUM_CH];
`endif

    // ------------------------------------------------------------------
    // Duration tick
    // ------------------------------------------------------------------
    assign tick = (tick_cnt_q == TICK_W'(TICK_DIV - 1));

    always_comb begin
        tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
    end

`ifdef TONE_FUZZ_EN
    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
`endif

    // ------------------------------------------------------------------
    // Channels
    // ------------------------------------------------------------------
    always_comb begin
        active_d = active_q;
        tone_d   = tone_q;
        done_d   = '0;
        lim      = '0;
        fz       = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            period_d[i] = period_q[i];
            count_d[i]  = count_q[i];
            rem_d[i]    = rem_q[i];
`ifdef TONE_FUZZ_EN
            fuzz_d[i]     = fuzz_q[i];
            fuzz_cur_d[i] = fuzz_cur_q[i];
            fz            = fuzz_cur_q[i];
`else
            fz            = '0;
`endif
            if (active_q[i]) begin
                // One bit wider than the period so period + fuzz cannot wrap.
                lim = CNT_W'(period_q[i]) + CNT_W'(fz) - CNT_W'(1);
                if (count_q[i] == lim) begin
                    count_d[i] = '0;
                    tone_d[i]  = ~tone_q[i];
`ifdef TONE_FUZZ_EN
                    fuzz_cur_d[i] = lfsr_q & fuzz_q[i];
`endif
                end else begin
                    count_d[i] = count_q[i] + CNT_W'(1);
                end
                // A non-zero remaining count on an active channel means timed.
                if (tick && (rem_q[i] != '0)) begin
                    rem_d[i] = rem_q[i] - DUR_W'(1);
                    if (rem_q[i] == DUR_W'(1)) begin
                        active_d[i] = 1'b0;
                        tone_d[i]   = 1'b0;
                        count_d[i]  = '0;
                        done_d[i]   = 1'b1;
                    end
                end
            end

            // Writes take priority over a same-cycle expiry, suppressing done.
            if (wr.wr_en && (wr.wr_ch == CH_W'(i))) begin
                done_d[i]  = 1'b0;
                count_d[i] = '0;
                tone_d[i]  = 1'b0;
                if (wr.wr_period != '0) begin
                    active_d[i] = 1'b1;
                    period_d[i] = wr.wr_period;
                    rem_d[i]    = wr.wr_dur;
`ifdef TONE_FUZZ_EN
                    fuzz_d[i]     = wr.wr_fuzz;
                    fuzz_cur_d[i] = lfsr_q & wr.wr_fuzz;
`endif
                end else begin
                    active_d[i] = 1'b0;
                    rem_d[i]    = '0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Mixer: first-order sigma-delta over the count of high tones
    // ------------------------------------------------------------------
    always_comb begin
        ones = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            ones = ones + SUM_W'(tone_q[i]);
        end
        sum = SUM_W'(acc_q) + ones;
        if (sum >= SUM_W'(NUM_CH)) begin
            acc_d   = CH_W'(sum - SUM_W'(NUM_CH));
            audio_d = 1'b1;
        end else begin
            acc_d   = CH_W'(sum);
            audio_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tick_cnt_q <= '0;
            active_q   <= '0;
            tone_q     <= '0;
            done_q     <= '0;
            acc_q      <= '0;
            audio_q    <= 1'b0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                period_q[i] <= '0;
                count_q[i]  <= '0;
                rem_q[i]    <= '0;
            end
        end else begin
            tick_cnt_q <= tick_cnt_d;
            active_q   <= active_d;
            tone_q     <= tone_d;
            done_q     <= done_d;
            acc_q      <= acc_d;
            audio_q    <= audio_d;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                period_q[i] <= period_d[i];
                count_q[i]  <= count_d[i];
                rem_q[i]    <= rem_d[i];
            end
        end
    end

`ifdef TONE_FUZZ_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lfsr_q <= 8'hA5;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                fuzz_q[i]     <= '0;
                fuzz_cur_q[i] <= '0;
            end
        end else begin
            lfsr_q <= lfsr_d;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                fuzz_q[i]     <= fuzz_d[i];
                fuzz_cur_q[i] <= fuzz_cur_d[i];
            end
        end
    end
`endif

    assign active    = active_q;
    assign tone      = tone_q;
    assign done      = done_q;
    assign audio_out = audio_q;

endmodule

// File: tb/tb_multi_tone_generator.sv
// -----------------------------------------------------------------------------
// tb_multi_tone_generator
// Directed bench for multi_tone_generator with CLK_HZ=1000, TICK_HZ=100
// (one duration tick every 10 clocks), NUM_CH=4. Inputs change and outputs
// are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_multi_tone_generator;

    localparam int NUM_CH = 4;
    localparam int PER_W  = 20;
    localparam int DUR_W  = 16;

    logic              clk = 1'b0;
    logic              resetn;
    logic [NUM_CH-1:0] active;
    logic [NUM_CH-1:0] tone;
    logic [NUM_CH-1:0] done;
    logic              audio_out;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt [NUM_CH];

    always #5 clk = ~clk;

    multi_tone_generator_if #(.NUM_CH(NUM_CH), .PER_W(PER_W), .DUR_W(DUR_W)) wr_bus ();

    multi_tone_generator #(
        .CLK_HZ (1000),
        .NUM_CH (NUM_CH),
        .PER_W  (PER_W),
        .DUR_W  (DUR_W),
        .TICK_HZ(100)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .wr       (wr_bus.slave),
        .active   (active),
        .tone     (tone),
        .done     (done),
        .audio_out(audio_out)
    );

    initial begin
        for (int i = 0; i < NUM_CH; i++) done_cnt[i] = 0;
    end

    always @(negedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (done[i]) done_cnt[i] = done_cnt[i] + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called on a falling edge; the load happens on the next rising edge and
    // the task returns on the falling edge just after it.
    task automatic wr(input int ch, input int per, input int dur, input int fz);
        wr_bus.wr_en     = 1'b1;
        wr_bus.wr_ch     = 2'(ch);
        wr_bus.wr_period = PER_W'(per);
        wr_bus.wr_dur    = DUR_W'(dur);
        wr_bus.wr_fuzz   = 8'(fz);
        @(negedge clk);
        wr_bus.wr_en     = 1'b0;
    endtask

    // Cycles until tone[ch] next changes (bounded).
    task automatic half_period(input int ch, output int n);
        logic v;
        v = tone[ch];
        n = 0;
        while (tone[ch] == v && n < 400) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, found, ones, trans, minh, maxh;
        logic prev_act, cur, prev;

        resetn           = 1'b0;
        wr_bus.wr_en     = 1'b0;
        wr_bus.wr_ch     = '0;
        wr_bus.wr_period = '0;
        wr_bus.wr_dur    = '0;
        wr_bus.wr_fuzz   = '0;
        wait_n(3);
        check("rst_active", active, 0);
        check("rst_tone", tone, 0);
        check("rst_done", done, 0);
        check("rst_audio", audio_out, 0);
        resetn = 1'b1;
        wait_n(2);

        // Continuous tone, half-period 100
        wr(0, 100, 0, 0);
        check("ch0_active", active[0], 1);
        check("ch0_tone_load", tone[0], 0);
        wait_n(99);
        check("ch0_pre_toggle", tone[0], 0);
        wait_n(1);
        check("ch0_first_toggle", tone[0], 1);
        half_period(0, n);
        check("ch0_half1", n, 100);
        half_period(0, n);
        check("ch0_half2", n, 100);
        check("ch0_still_active", active[0], 1);

        // Stop mid high half-period
        wait_n(50);
        check("ch0_mid_high", tone[0], 1);
        wr(0, 0, 0, 0);
        check("stop_tone", tone[0], 0);
        check("stop_active", active[0], 0);
        check("stop_done", done[0], 0);
        wait_n(150);
        check("stop_hold_tone", tone[0], 0);
        check("stop_hold_active", active[0], 0);

        // Timed tone: 3 ticks of 10 clocks
        wr(1, 4, 3, 0);
        found = 0;
        prev_act = active[1];
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 4) check("ch1_tone_4", tone[1], 1);
            if (done[1]) begin
                found = k;
                check("exp_prev_active", prev_act, 1);
                check("exp_active", active[1], 0);
                check("exp_tone", tone[1], 0);
                break;
            end
            prev_act = active[1];
        end
        check("exp_window", (found >= 21 && found <= 30), 1);
        @(negedge clk);
        check("done_one_cycle", done[1], 0);

        // Write colliding with an expiry: reload wins, no done
        wr(1, 4, 1, 0);
        found = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (done[1]) begin
                found = k;
                break;
            end
        end
        check("tick_find", (found >= 1 && found <= 10), 1);
        wr(1, 4, 1, 0);
        wait_n(8);
        wr(1, 6, 0, 0);
        check("collide_no_done", done[1], 0);
        check("collide_active", active[1], 1);
        wait_n(5);
        check("collide_tone_pre", tone[1], 0);
        wait_n(1);
        check("collide_tone", tone[1], 1);
        wait_n(40);
        check("collide_continuous", active[1], 1);
        wr(1, 0, 0, 0);
        wait_n(3);
        check("silent_tone", tone, 0);
        check("silent_audio", audio_out, 0);

        // Mixer: staggered loads so all four tones rise together
        wr(0, 203, 0, 0);
        wr(1, 202, 0, 0);
        wr(2, 201, 0, 0);
        wr(3, 200, 0, 0);
        wait_n(200);
        check("all_high", tone, 4'hF);
        wait_n(2);
        ones = 0;
        for (int i = 0; i < 100; i++) begin
            ones += int'(audio_out);
            @(negedge clk);
        end
        check("mix_all_ones", ones, 100);
        wr(2, 0, 0, 0);
        wr(3, 0, 0, 0);
        check("two_high", tone, 4'b0011);
        wait_n(2);
        ones  = 0;
        trans = 0;
        prev  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cur = audio_out;
            ones += int'(cur);
            if (i > 0 && cur != prev) trans++;
            prev = cur;
            @(negedge clk);
        end
        check("mix_half_ones", ones, 20);
        check("mix_alternate", trans, 39);
        wr(0, 0, 0, 0);
        wr(1, 0, 0, 0);

        // Jitter mask
`ifdef TONE_FUZZ_EN
        wr(0, 50, 0, 0);
        for (int i = 0; i < 3; i++) begin
            half_period(0, n);
            check("fuzz0_half", n, 50);
        end
        wr(0, 50, 0, 8'hFF);
        minh = 1000;
        maxh = 0;
        for (int i = 0; i < 6; i++) begin
            half_period(0, n);
            check("fuzzff_range", (n >= 50 && n <= 305), 1);
            if (n < minh) minh = n;
            if (n > maxh) maxh = n;
        end
        check("fuzzff_varies", (maxh > minh), 1);
`else
        minh = 0;
        maxh = 0;
        wr(0, 50, 0, 8'hFF);
        wait_n(49);
        check("nofuzz_pre", tone[0], 0);
        wait_n(1);
        check("nofuzz_first", tone[0], 1);
        for (int i = 0; i < 3; i++) begin
            half_period(0, n);
            check("nofuzz_half", n, 50);
        end
`endif

        // Asynchronous reset mid-tone
        wait_n(10);
        #2;
        resetn = 1'b0;
        #1;
        check("arst_active", active, 0);
        check("arst_tone", tone, 0);
        check("arst_done", done, 0);
        check("arst_audio", audio_out, 0);
        @(negedge clk);
        resetn = 1'b1;
        wait_n(200);
        check("post_rst_active", active, 0);
        check("post_rst_tone", tone, 0);
        check("post_rst_audio", audio_out, 0);

        check("done_cnt0", done_cnt[0], 0);
        check("done_cnt1", done_cnt[1], 2);
        check("done_cnt2", done_cnt[2], 0);
        check("done_cnt3", done_cnt[3], 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multi_tone_generator.md
MULTI_TONE_GENERATOR -- requirements
Module: multi_tone_generator

Interface
REQ-001 SHALL have parameter CLK_HZ, default 27000000, clock frequency in Hz.
REQ-002 SHALL have parameter NUM_CH, default 4, number of tone channels (1..8).
REQ-003 SHALL have parameter PER_W, default 20, half-period field width.
REQ-004 SHALL have parameter DUR_W, default 16, duration field width.
REQ-005 SHALL have parameter TICK_HZ, default 1000, duration tick rate in Hz.
REQ-006 SHALL have port clk, input, 1, single system clock; all logic on rising edge.
REQ-007 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port wr_en, input, 1, one-cycle channel-load strobe.
REQ-009 SHALL have port wr_ch, input, max(1,$clog2(NUM_CH)), target channel; values >= NUM_CH are ignored.
REQ-010 SHALL have port wr_period, input, PER_W, half-period in clk cycles; 0 = stop.
REQ-011 SHALL have port wr_dur, input, DUR_W, duration in ticks; 0 = continuous.
REQ-012 SHALL have port wr_fuzz, input, 8, jitter mask.
REQ-013 SHALL have port active, output, NUM_CH, channel-sounding flags.
REQ-014 SHALL have port tone, output, NUM_CH, per-channel square waves.
REQ-015 SHALL have port done, output, NUM_CH, one-cycle duration-expiry pulses.
REQ-016 SHALL have port audio_out, output, 1, mixed 1-bit audio.

Function
REQ-017 SHALL free-run a tick counter emitting a one-cycle tick every CLK_HZ/TICK_HZ cycles.
REQ-018 On wr_en with wr_period != 0, SHALL load period, duration and fuzz into channel wr_ch, clear its count and tone, and set active on the next edge.
REQ-019 On wr_en with wr_period == 0, SHALL clear active and tone of wr_ch on the next edge, with no done pulse.
REQ-020 While active, count SHALL increment each cycle; when count reaches period+fuzz_cur-1, count SHALL reset to 0, tone SHALL toggle, and fuzz_cur SHALL be resampled.
REQ-021 The first toggle SHALL occur exactly period+fuzz_cur cycles after the load edge; the compare SHALL be PER_W+1 bits wide, with no overflow.
REQ-022 With duration != 0, each tick SHALL decrement remaining; on the 1->0 transition, active and tone SHALL clear and done SHALL pulse for one cycle.
REQ-023 With duration == 0, the channel SHALL sound until rewritten.
REQ-024 When a write and an expiry hit the same channel in the same cycle, the write SHALL win and no done SHALL pulse.
REQ-025 Inactive channels SHALL hold count 0 and tone 0.
REQ-026 Mixer: s = number of tone bits high; accumulator a in [0,NUM_CH-1]; if a+s >= NUM_CH, a <= a+s-NUM_CH and audio_out <= 1, else a <= a+s and audio_out <= 0 (registered, first-order sigma-delta).

Reset
REQ-027 resetn low SHALL asynchronously clear active, tone, done, audio_out, all counters, the accumulator and the tick counter to 0, and set the LFSR to 8'hA5.
REQ-028 Reset mid-tone SHALL silence all channels; on release, no channel SHALL sound until rewritten.

Configuration
REQ-029 With TONE_FUZZ_EN defined, an 8-bit LFSR (x^8+x^6+x^5+x^4+1) SHALL advance every cycle and fuzz_cur SHALL equal lfsr AND the fuzz register.
REQ-030 Without TONE_FUZZ_EN, fuzz_cur SHALL be 0, wr_fuzz SHALL be ignored but still present, and no LFSR SHALL be built.

Verification
REQ-031 Reset: assert resetn=0 mid-operation -> active, tone, done and audio_out all 0 immediately.
REQ-032 Write ch0, period=100, dur=0 -> tone[0] toggles every 100 cycles, first toggle 100 cycles after the load edge, active[0]=1 indefinitely.
REQ-033 With CLK_HZ=1000 and TICK_HZ=100, write ch1, period=4, dur=3 -> done[1] pulses once, 21..30 cycles after the load, and active[1] and tone[1] fall in that cycle.
REQ-034 With NUM_CH=4 and all tones forced high -> audio_out constantly 1; with exactly two high -> audio_out alternates 1,0 (50% duty).
REQ-035 Write period=0 to an active channel mid-half-period -> tone=0 and active=0 next cycle, and done stays 0; write plus expiry in the same cycle -> channel reloads with no done.
REQ-036 With TONE_FUZZ_EN, period=50, fuzz=0 -> every half-period is 50; fuzz=8'hFF -> half-periods span 50..305 and vary. Without the macro, fuzz=8'hFF -> every half-period is exactly 50.
